// File: rtl/fifo_drain_serializer.sv
// Drains words from a synchronous FIFO and emits them as OUT_WIDTH-bit slices on a
// valid/ready stream; a one-word hold register covers the FIFO's one-cycle read latency.
module fifo_drain_serializer #(
   parameter int WIDTH     = 32,
   parameter int OUT_WIDTH = 8,
   parameter int MSB_FIRST = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 fifo_empty,
   input  logic [WIDTH-1:0]     fifo_d_out,
   output logic                 fifo_r_enb,
   output logic [OUT_WIDTH-1:0] m_data,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic                 m_last,
   output logic                 busy,
   output logic [15:0]          word_count
);

   localparam int RATIO = WIDTH / OUT_WIDTH;
   localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

   logic                 rd_inflight;
   logic                 hold_valid;
   logic [WIDTH-1:0]     hold_word;
   logic                 shift_valid;
   logic [WIDTH-1:0]     shift_word;
   logic [IDX_W-1:0]     slice_idx;
   logic [IDX_W-1:0]     sel;
   logic [OUT_WIDTH-1:0] slices [RATIO];
   logic                 accept;
   logic                 last_accept;

   // Stream handshake: a slice transfers on a rising edge where m_valid && m_ready;
   // once m_valid is high, m_data/m_last stay stable until that transfer happens.
   assign accept      = shift_valid && m_ready;
   assign last_accept = accept && (slice_idx == LAST_IDX);

   // A new read is only issued when its data is guaranteed a place (shift or hold).
   assign fifo_r_enb = !fifo_empty && !rd_inflight && !hold_valid && !reset;

   always_comb begin
      for (int i = 0; i < RATIO; i++) begin
         slices[i] = shift_word[i*OUT_WIDTH +: OUT_WIDTH];
      end
   end

   assign sel     = (MSB_FIRST != 0) ? (LAST_IDX - slice_idx) : slice_idx;
   assign m_data  = slices[sel];
   assign m_valid = shift_valid;
   assign m_last  = shift_valid && (slice_idx == LAST_IDX);
   assign busy    = rd_inflight || hold_valid || shift_valid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_inflight <= 1'b0;
         hold_valid  <= 1'b0;
         hold_word   <= '0;
         shift_valid <= 1'b0;
         shift_word  <= '0;
         slice_idx   <= '0;
         word_count  <= '0;
      end else begin
         rd_inflight <= fifo_r_enb;

         if (accept) begin
            if (slice_idx == LAST_IDX) begin
               slice_idx  <= '0;
               word_count <= word_count + 16'd1;
            end else begin
               slice_idx <= slice_idx + IDX_W'(1);
            end
         end

         // Hold and an in-flight read never coexist, so these branches are exclusive.
         if (last_accept) begin
            if (hold_valid) begin
               shift_word <= hold_word;
               hold_valid <= 1'b0;
            end else if (rd_inflight) begin
               shift_word <= fifo_d_out;
            end else begin
               shift_valid <= 1'b0;
            end
         end else if (rd_inflight) begin
            if (!shift_valid) begin
               shift_word  <= fifo_d_out;
               shift_valid <= 1'b1;
            end else begin
               hold_word  <= fifo_d_out;
               hold_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_fifo_drain_serializer.sv
// Bench for fifo_drain_serializer: a queue-based FIFO model feeds an MSB-first and an
// LSB-first instance in lockstep; a scoreboard checks every accepted slice.
module tb_fifo_drain_serializer;

   logic        clk = 1'b0;
   logic        reset;
   logic        fifo_empty = 1'b1;
   logic [31:0] fifo_d_out = '0;
   logic        m_ready;

   logic        renb0, valid0, last0, busy0;
   logic [7:0]  data0;
   logic [15:0] wc0;
   logic        renb1, valid1, last1, busy1;
   logic [7:0]  data1;
   logic [15:0] wc1;

   int n_checks = 0;
   int n_errors = 0;
   int exp_words = 0;

   // Each entry: {last, msb_first_slice, lsb_first_slice}
   logic [16:0] exp_q[$];
   logic [31:0] mem_q[$];
   logic [31:0] wr_q[$];
   logic        prev_renb = 1'b0;

   typedef struct {
      logic [31:0] word;
      logic [31:0] exp_msb;   // slices in emission order, first slice in the top byte
      logic [31:0] exp_lsb;
   } vec_t;
   vec_t vecs [6];

   fifo_drain_serializer #(.WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1)) dut0 (
      .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_d_out(fifo_d_out),
      .fifo_r_enb(renb0), .m_data(data0), .m_valid(valid0), .m_ready(m_ready),
      .m_last(last0), .busy(busy0), .word_count(wc0));

   fifo_drain_serializer #(.WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(0)) dut1 (
      .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_d_out(fifo_d_out),
      .fifo_r_enb(renb1), .m_data(data1), .m_valid(valid1), .m_ready(m_ready),
      .m_last(last1), .busy(busy1), .word_count(wc1));

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // ---------------- FIFO model ----------------
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_q.delete();
         wr_q.delete();
         fifo_empty <= 1'b1;
         fifo_d_out <= '0;
      end else begin
         if (renb0 && mem_q.size() > 0) fifo_d_out <= mem_q.pop_front();
         while (wr_q.size() > 0) mem_q.push_back(wr_q.pop_front());
         fifo_empty <= (mem_q.size() == 0);
      end
   end

   // ---------------- checker ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      logic [16:0] e;
      if (!reset) begin
         if (valid0 && m_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_slice: got %0h expected none at %0t", data0, $time);
            end else begin
               e = exp_q.pop_front();
               check("slice_msb_first", {last0, data0}, {e[16], e[15:8]});
               check("slice_lsb_first", {last1, data1}, {e[16], e[7:0]});
               if (e[16]) exp_words++;
            end
         end
         check("lsb_inst_ctrl", {renb1, valid1, busy1, wc1}, {renb0, valid0, busy0, wc0});
         if (renb0) check("renb_rule", {prev_renb, fifo_empty}, 2'b00);
      end
      prev_renb <= renb0;
   end

   // ---------------- driver tasks ----------------
   task automatic push_word(input logic [31:0] w);
      wr_q.push_back(w);
   endtask

   task automatic expect_word(input logic [31:0] msb_cat, input logic [31:0] lsb_cat);
      for (int k = 0; k < 4; k++) begin
         exp_q.push_back({(k == 3), msb_cat[31-8*k -: 8], lsb_cat[31-8*k -: 8]});
      end
   endtask

   task automatic wait_idle(input string name, input int limit);
      bit done = 0;
      for (int c = 0; c < limit; c++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !busy0) begin
            done = 1;
            break;
         end
      end
      check({name, "_idle"}, done, 1'b1);
   endtask

   task automatic wait_slice(input string name, input logic [7:0] val, input int limit);
      bit seen = 0;
      for (int c = 0; c < limit; c++) begin
         @(negedge clk);
         if (valid0 && data0 == val) begin
            seen = 1;
            break;
         end
      end
      check({name, "_seen"}, seen, 1'b1);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int reads;
      int gaps;
      bit got;
      logic [31:0] w;

      vecs[0] = '{32'hAABBCCDD, 32'hAABBCCDD, 32'hDDCCBBAA};
      vecs[1] = '{32'h55667788, 32'h55667788, 32'h88776655};
      vecs[2] = '{32'h11223344, 32'h11223344, 32'h44332211};
      vecs[3] = '{32'h00000000, 32'h00000000, 32'h00000000};
      vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
      vecs[5] = '{32'h01234567, 32'h01234567, 32'h67452301};

      reset   = 1'b1;
      m_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_outputs", {renb0, valid0, last0, busy0, data0, wc0}, '0);
      check("reset_lsb_data", data1, 8'h00);
      reset = 1'b0;

      // Empty FIFO: nothing may move for 100 cycles
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         check("empty_idle", {renb0, valid0, busy0}, 3'b000);
      end

      // Single word with exact latency
      push_word(32'hAABBCCDD);
      expect_word(32'hAABBCCDD, 32'hDDCCBBAA);
      @(negedge clk);
      check("single_renb_T", {renb0, valid0}, 2'b10);
      @(negedge clk);
      check("single_T1", {renb0, valid0}, 2'b00);
      @(negedge clk);
      check("single_first_T2", {valid0, last0, data0}, {2'b10, 8'hAA});
      @(negedge clk);
      check("single_second", {valid0, last0, data0}, {2'b10, 8'hBB});
      @(negedge clk);
      check("single_third", {valid0, last0, data0}, {2'b10, 8'hCC});
      @(negedge clk);
      check("single_last", {valid0, last0, data0}, {2'b11, 8'hDD});
      @(negedge clk);
      check("single_done", {valid0, busy0, wc0}, {2'b00, 16'd1});

      // Table-driven vectors, one word at a time
      for (int v = 0; v < 6; v++) begin
         push_word(vecs[v].word);
         expect_word(vecs[v].exp_msb, vecs[v].exp_lsb);
         wait_idle("vector", 50);
         check("vector_word_count", wc0, 16'(exp_words));
      end

      // Full drain of 1024 words, gap-free after the first slice
      for (int i = 0; i < 1024; i++) begin
         w = i;
         push_word(w);
         expect_word(w, {w[7:0], w[15:8], w[23:16], w[31:24]});
      end
      got = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (valid0) begin
            got = 1;
            break;
         end
      end
      check("drain_start", got, 1'b1);
      gaps = 0;
      for (int c = 0; c < 4095; c++) begin
         @(negedge clk);
         if (!valid0) gaps++;
      end
      check("drain_gaps", gaps, 0);
      wait_idle("drain", 50);
      check("drain_word_count", wc0, 16'(exp_words));
      check("drain_fifo_empty", fifo_empty, 1'b1);

      // Backpressure on the second slice of 0x55667788
      push_word(32'h55667788);
      push_word(32'h01020304);
      push_word(32'h0A0B0C0D);
      expect_word(32'h55667788, 32'h88776655);
      expect_word(32'h01020304, 32'h04030201);
      expect_word(32'h0A0B0C0D, 32'h0D0C0B0A);
      wait_slice("bp_first", 8'h55, 20);
      @(posedge clk);
      #1 m_ready = 1'b0;
      reads = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check("bp_stable", {valid0, last0, data0}, {2'b10, 8'h66});
         if (renb0) reads++;
      end
      check("bp_reads_le1", (reads > 1), 1'b0);
      @(posedge clk);
      #1 m_ready = 1'b1;
      wait_idle("bp", 60);
      check("bp_word_count", wc0, 16'(exp_words));

      // Asynchronous reset between slices BB and CC
      push_word(32'hAABBCCDD);
      expect_word(32'hAABBCCDD, 32'hDDCCBBAA);
      wait_slice("rst_bb", 8'hBB, 20);
      @(posedge clk);
      #1 reset = 1'b1;
      #1;
      check("rst_async_outputs", {renb0, valid0, last0, busy0, data0, wc0}, '0);
      exp_q.delete();
      exp_words = 0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      push_word(32'h11223344);
      expect_word(32'h11223344, 32'h44332211);
      wait_idle("post_reset", 50);
      check("post_reset_word_count", wc0, 16'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
